// File: rtl/bits_counter.sv
// bits_counter: modulo-MODULUS 3-bit binary counter with decoded code outputs.
//   clk   - single clock, rising edge
//   rst   - synchronous active-high reset
//   count - binary count register, 0..MODULUS-1
//   out2..out0 - presented code: binary bits of count by default,
//                Gray code of count when BITS_COUNTER_GRAY_EN is defined
module bits_counter #(
  parameter int unsigned MODULUS = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic [2:0] count
);

  localparam logic [2:0] LAST = 3'(MODULUS - 1);

  logic [2:0] count_q;
  logic [2:0] count_d;

  // ">=" rather than "==" so an out-of-range value can never persist.
  always_comb begin
    count_d = count_q;
    if (count_q >= LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef BITS_COUNTER_GRAY_EN
  assign out2 = count_q[2];
  assign out1 = count_q[2] ^ count_q[1];
  assign out0 = count_q[1] ^ count_q[0];
`else
  assign out2 = count_q[2];
  assign out1 = count_q[1];
  assign out0 = count_q[0];
`endif

endmodule

// File: tb/tb_bits_counter.sv
module tb_bits_counter;

  localparam int unsigned NSTEP = 26;

  logic       clk;
  logic       rst;
  logic       out0_8, out1_8, out2_8;
  logic [2:0] count_8;
  logic       out0_5, out1_5, out2_5;
  logic [2:0] count_5;

  int unsigned n_cmp;
  int unsigned n_bad;

  bits_counter #(.MODULUS(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .out0  (out0_8),
    .out1  (out1_8),
    .out2  (out2_8),
    .count (count_8)
  );

  bits_counter #(.MODULUS(5)) dut5 (
    .clk   (clk),
    .rst   (rst),
    .out0  (out0_5),
    .out1  (out1_5),
    .out2  (out2_5),
    .count (count_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rst value driven before each edge, and hand-computed counts after it.
  int rst_v [NSTEP] = '{1,1,1, 0,0,0,0,0,0,0,0,0, 0,0,0,0, 1, 0, 0,0,0,0,0,0, 1, 0};
  int exp8  [NSTEP] = '{0,0,0, 1,2,3,4,5,6,7,0,1, 2,3,4,5, 0, 1, 2,3,4,5,6,7, 0, 1};
  int exp5  [NSTEP] = '{0,0,0, 1,2,3,4,0,1,2,3,4, 0,1,2,3, 0, 1, 2,3,4,0,1,2, 0, 1};

`ifdef BITS_COUNTER_GRAY_EN
  int code_lut [8] = '{0,1,3,2,6,7,5,4};
`else
  int code_lut [8] = '{0,1,2,3,4,5,6,7};
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(NSTEP); i++) begin
      rst = rst_v[i][0];
      @(posedge clk);
      #1;
      check($sformatf("count8[%0d]", i), int'(count_8), exp8[i]);
      check($sformatf("out8[%0d]", i), int'({out2_8, out1_8, out0_8}), code_lut[exp8[i]]);
      check($sformatf("count5[%0d]", i), int'(count_5), exp5[i]);
      check($sformatf("out5[%0d]", i), int'({out2_5, out1_5, out0_5}), code_lut[exp5[i]]);
      check($sformatf("range5[%0d]", i), int'(count_5 < 3'd5), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
